core_hazard_ctrl: RTL and testbench
===================================

Name: core_hazard_ctrl

Overview:
- Pipeline sequencer for the decode stage and its neighbours.
- Produces the enable, kill and nop controls that the IF, decode and EXE registers consume.
- Produces the PC-redirect strobe and the operand forwarding selects.
- Tracks outstanding L1I/L1D misses and post-branch flush windows with a small FSM and counter.

Parameters:
- FLUSH_CYCLES, 2: number of cycles decode is killed after a redirect; legal range 1..7.
- REG_AW, 5: register-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- dec_cmd_in  in  2  hazard command of the decode instruction: 00 OTHER, 01 BRNCH, 10 JUMP, 11 LOAD
- dec_rs1_in  in  REG_AW  decode source 1
- dec_rs2_in  in  REG_AW  decode source 2
- exe_cmd_in  in  2  hazard command in EXE; same encoding
- exe_rd_in  in  REG_AW  EXE destination
- exe_we_in  in  1  EXE writes the register file
- mem_rd_in  in  REG_AW  MEM destination
- mem_we_in  in  1  MEM writes the register file
- exe_brnch_taken_in  in  1  branch resolved taken; meaningful only when exe_cmd_in=BRNCH
- l1i_ack_in  in  1  instruction fetch data valid
- l1d_req_val_in  in  1  data cache request outstanding from EXE/MEM
- l1d_ack_in  in  1  data cache response
- if_enb_out  out  1  IF/PC register enable
- dec_enb_out  out  1  decode output register enable
- exe_enb_out  out  1  EXE register enable
- dec_kill_out  out  1  zero the decode output register
- dec_nop_gen_out  out  1  decode emits a bubble
- pc_redirect_out  out  1  select the EXE target PC
- fwd_a_sel_out  out  2  src1 select: 00 regfile, 01 EXE, 10 MEM
- fwd_b_sel_out  out  2  src2 select; same encoding

Behaviour:
- FSM states: RUN, FLUSH, IWAIT, DWAIT. A 3-bit flush counter fcnt is used in FLUSH.
- While rst=1: state is RUN next cycle and fcnt=0. Outputs during reset: all enables 0, dec_kill_out=1, dec_nop_gen_out=1, pc_redirect_out=0, fwd selects 00.
- Event predicates, evaluated each cycle:
  - dmiss = l1d_req_val_in & ~l1d_ack_in
  - redir = (exe_cmd_in=BRNCH & exe_brnch_taken_in) | exe_cmd_in=JUMP
  - ldu = exe_cmd_in=LOAD & exe_we_in & exe_rd_in≠0 & (exe_rd_in=dec_rs1_in | exe_rd_in=dec_rs2_in)
  - imiss = ~l1i_ack_in
- Default outputs in RUN: all enables 1, kill 0, nop 0, redirect 0.
- Priority, any state: dmiss > redir > ldu > imiss.
- RUN:
  - dmiss: if_enb, dec_enb and exe_enb = 0 in the same cycle; next state DWAIT.
  - redir: pc_redirect_out=1, dec_kill_out=1, dec_nop_gen_out=1 in the same cycle (Mealy). If FLUSH_CYCLES=1, stay RUN; else go to FLUSH with fcnt=FLUSH_CYCLES-1.
  - ldu: one bubble; if_enb=0, dec_enb=0, dec_kill_out=1 this cycle; stay RUN. The bubble clears exe_rd, so there is no re-detection.
  - imiss: dec_nop_gen_out=1, if_enb=1; next state IWAIT.
- FLUSH:
  - dec_kill_out=1, dec_nop_gen_out=1; fcnt decrements.
  - Go to RUN when fcnt reaches 1 on entry to the cycle.
  - imiss and ldu are ignored.
  - dmiss freezes all enables and fcnt holds.
- IWAIT: dec_nop_gen_out=1 until l1i_ack_in=1, then RUN (ack cycle outputs RUN defaults). dmiss takes precedence and goes to DWAIT.
- DWAIT:
  - All enables 0 while ~l1d_ack_in.
  - On the ack cycle, enables return to 1; next state RUN.
  - A redirect present in EXE during the freeze is acted on in the first RUN cycle.
- Forwarding (combinational, state-independent), per source s:
  - EXE hit: exe_we_in & exe_rd_in≠0 & exe_rd_in=s & exe_cmd_in≠LOAD → 01.
  - Else MEM hit: mem_we_in & mem_rd_in≠0 & mem_rd_in=s → 10.
  - Else 00.
  - EXE has priority over MEM. Register 0 is never forwarded.
- Reset asserted mid-FLUSH or mid-DWAIT aborts to RUN; fcnt is cleared.

Optional Feature:
- Macro: CORE_HAZARD_PERF_CNT_EN.
- When defined, adds outputs stall_cnt_out[31:0] and flush_cnt_out[31:0].
  - stall_cnt_out increments each cycle dec_enb_out=0 and rst=0.
  - flush_cnt_out increments each cycle pc_redirect_out=1.
  - Both saturate at 0xFFFFFFFF and clear on rst.
- When undefined, both ports exist but are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: exe_cmd=11, exe_we=1, exe_rd=5, dec_rs2=5 → exactly one cycle with if_enb=0, dec_enb=0, dec_kill=1; the next cycle is all-RUN defaults.
- Taken branch, FLUSH_CYCLES=2: exe_cmd=01, taken=1 → cycle 0: redirect=1, kill=1. Cycle 1: kill=1, redirect=0. Cycle 2: RUN.
- Simultaneous events: redir and ldu in the same cycle → redirect path only, no ldu bubble. dmiss and redir in the same cycle → freeze first, redirect asserted on the first cycle after l1d_ack.
- L1D miss: l1d_req_val=1, ack low 4 cycles → enables 0 for 4 cycles, 1 on the ack cycle; reset asserted in the 2nd wait cycle → RUN defaults after reset release.
- Forwarding: exe_rd=mem_rd=7, both we=1, dec_rs1=7 → fwd_a=01. exe_we=0 → fwd_a=10. dec_rs1=0 → fwd_a=00.
- With CORE_HAZARD_PERF_CNT_EN: 3 redirects and 5 stall cycles → flush_cnt=3, stall_cnt=5. Without the macro, both read 0.

Source files
------------

// File: rtl/core_hazard_ctrl.sv
// Decode-stage hazard sequencer: stall, kill, redirect and forwarding selects.
// CORE_HAZARD_PERF_CNT_EN builds the stall/flush performance counters.
module core_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_AW       = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        dec_cmd_in,
   input  logic [REG_AW-1:0] dec_rs1_in,
   input  logic [REG_AW-1:0] dec_rs2_in,
   input  logic [1:0]        exe_cmd_in,
   input  logic [REG_AW-1:0] exe_rd_in,
   input  logic              exe_we_in,
   input  logic [REG_AW-1:0] mem_rd_in,
   input  logic              mem_we_in,
   input  logic              exe_brnch_taken_in,
   input  logic              l1i_ack_in,
   input  logic              l1d_req_val_in,
   input  logic              l1d_ack_in,
   output logic              if_enb_out,
   output logic              dec_enb_out,
   output logic              exe_enb_out,
   output logic              dec_kill_out,
   output logic              dec_nop_gen_out,
   output logic              pc_redirect_out,
   output logic [1:0]        fwd_a_sel_out,
   output logic [1:0]        fwd_b_sel_out,
   output logic [31:0]       stall_cnt_out,
   output logic [31:0]       flush_cnt_out
);

   localparam logic [1:0] CMD_BRNCH = 2'b01;
   localparam logic [1:0] CMD_JUMP  = 2'b10;
   localparam logic [1:0] CMD_LOAD  = 2'b11;
   localparam logic [2:0] FC_INIT   = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RUN,
      S_FLUSH,
      S_IWAIT,
      S_DWAIT
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [2:0] r_fcnt;
   logic [2:0] w_fcnt_nxt;

   logic w_dmiss;
   logic w_redir;
   logic w_ldu;
   logic w_imiss;
   logic w_exe_fwd_ok;
   logic w_mem_fwd_ok;
   logic w_unused;

   // decode's own command carries no hazard information here
   assign w_unused = ^dec_cmd_in;

   assign w_dmiss = l1d_req_val_in & ~l1d_ack_in;
   assign w_redir = ((exe_cmd_in == CMD_BRNCH) & exe_brnch_taken_in)
                  | (exe_cmd_in == CMD_JUMP);
   assign w_ldu   = (exe_cmd_in == CMD_LOAD) & exe_we_in
                  & (exe_rd_in != '0)
                  & ((exe_rd_in == dec_rs1_in) | (exe_rd_in == dec_rs2_in));
   assign w_imiss = ~l1i_ack_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_fcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_fcnt_nxt      = r_fcnt;
      if_enb_out      = 1'b1;
      dec_enb_out     = 1'b1;
      exe_enb_out     = 1'b1;
      dec_kill_out    = 1'b0;
      dec_nop_gen_out = 1'b0;
      pc_redirect_out = 1'b0;
      if (rst) begin
         w_state_nxt     = S_RUN;
         w_fcnt_nxt      = '0;
         if_enb_out      = 1'b0;
         dec_enb_out     = 1'b0;
         exe_enb_out     = 1'b0;
         dec_kill_out    = 1'b1;
         dec_nop_gen_out = 1'b1;
      end else begin
         unique case (r_state)
            // IWAIT only differs from RUN by waiting on the fetch ack,
            // which the imiss branch already covers
            S_RUN, S_IWAIT: begin
               if (w_dmiss) begin
                  if_enb_out  = 1'b0;
                  dec_enb_out = 1'b0;
                  exe_enb_out = 1'b0;
                  w_state_nxt = S_DWAIT;
               end else if (w_redir) begin
                  pc_redirect_out = 1'b1;
                  dec_kill_out    = 1'b1;
                  dec_nop_gen_out = 1'b1;
                  if (FLUSH_CYCLES == 1) begin
                     w_state_nxt = S_RUN;
                  end else begin
                     w_state_nxt = S_FLUSH;
                     w_fcnt_nxt  = FC_INIT;
                  end
               end else if (w_ldu) begin
                  if_enb_out   = 1'b0;
                  dec_enb_out  = 1'b0;
                  dec_kill_out = 1'b1;
                  w_state_nxt  = S_RUN;
               end else if (w_imiss) begin
                  dec_nop_gen_out = 1'b1;
                  w_state_nxt     = S_IWAIT;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            S_FLUSH: begin
               dec_kill_out    = 1'b1;
               dec_nop_gen_out = 1'b1;
               if (w_dmiss) begin
                  if_enb_out  = 1'b0;
                  dec_enb_out = 1'b0;
                  exe_enb_out = 1'b0;
               end else if (w_redir) begin
                  pc_redirect_out = 1'b1;
                  if (FLUSH_CYCLES == 1) begin
                     w_state_nxt = S_RUN;
                     w_fcnt_nxt  = '0;
                  end else begin
                     w_fcnt_nxt = FC_INIT;
                  end
               end else if (r_fcnt <= 3'd1) begin
                  w_state_nxt = S_RUN;
                  w_fcnt_nxt  = '0;
               end else begin
                  w_fcnt_nxt = r_fcnt - 3'd1;
               end
            end
            S_DWAIT: begin
               if (!l1d_ack_in) begin
                  if_enb_out  = 1'b0;
                  dec_enb_out = 1'b0;
                  exe_enb_out = 1'b0;
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
            default: w_state_nxt = S_RUN;
         endcase
      end
   end

   assign w_exe_fwd_ok = exe_we_in & (exe_rd_in != '0)
                       & (exe_cmd_in != CMD_LOAD);
   assign w_mem_fwd_ok = mem_we_in & (mem_rd_in != '0);

   assign fwd_a_sel_out =
      rst ? 2'b00 :
      (w_exe_fwd_ok && exe_rd_in == dec_rs1_in) ? 2'b01 :
      (w_mem_fwd_ok && mem_rd_in == dec_rs1_in) ? 2'b10 : 2'b00;

   assign fwd_b_sel_out =
      rst ? 2'b00 :
      (w_exe_fwd_ok && exe_rd_in == dec_rs2_in) ? 2'b01 :
      (w_mem_fwd_ok && mem_rd_in == dec_rs2_in) ? 2'b10 : 2'b00;

`ifdef CORE_HAZARD_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (!dec_enb_out && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (pc_redirect_out && r_flush_cnt != '1)
            r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt_out = r_stall_cnt;
   assign flush_cnt_out = r_flush_cnt;
`else
   assign stall_cnt_out = '0;
   assign flush_cnt_out = '0;
`endif

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Bench for core_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-level reference model.
module tb_core_hazard_ctrl;

   localparam int FC = 2;
`ifdef CORE_HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [1:0]  dec_cmd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic [1:0]  exe_cmd;
   logic [4:0]  exe_rd;
   logic        exe_we;
   logic [4:0]  mem_rd;
   logic        mem_we;
   logic        taken;
   logic        iack;
   logic        dreq;
   logic        dack;
   logic        if_enb;
   logic        dec_enb;
   logic        exe_enb;
   logic        kill;
   logic        nop;
   logic        redir;
   logic [1:0]  fwa;
   logic [1:0]  fwb;
   logic [31:0] stall_cnt;
   logic [31:0] flush_cnt;

   int n_vec;
   int n_err;

   // model state: remaining kill cycles, data-miss freeze, counters
   int          m_kills;
   bit          m_dwait;
   logic [31:0] m_stall;
   logic [31:0] m_flush;

   core_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_AW(5)) dut (
      .clk                (clk),
      .rst                (rst),
      .dec_cmd_in         (dec_cmd),
      .dec_rs1_in         (dec_rs1),
      .dec_rs2_in         (dec_rs2),
      .exe_cmd_in         (exe_cmd),
      .exe_rd_in          (exe_rd),
      .exe_we_in          (exe_we),
      .mem_rd_in          (mem_rd),
      .mem_we_in          (mem_we),
      .exe_brnch_taken_in (taken),
      .l1i_ack_in         (iack),
      .l1d_req_val_in     (dreq),
      .l1d_ack_in         (dack),
      .if_enb_out         (if_enb),
      .dec_enb_out        (dec_enb),
      .exe_enb_out        (exe_enb),
      .dec_kill_out       (kill),
      .dec_nop_gen_out    (nop),
      .pc_redirect_out    (redir),
      .fwd_a_sel_out      (fwa),
      .fwd_b_sel_out      (fwb),
      .stall_cnt_out      (stall_cnt),
      .flush_cnt_out      (flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] fsel(input logic [4:0] s);
      if (exe_we && exe_rd != 0 && exe_rd == s && exe_cmd != 2'd3)
         return 2'b01;
      if (mem_we && mem_rd != 0 && mem_rd == s)
         return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [9:0] ov(input logic [2:0] en, input bit k,
                                     input bit n, input bit r,
                                     input logic [1:0] a,
                                     input logic [1:0] b);
      return {en, k, n, r, a, b};
   endfunction

   task automatic idle();
      rst = 0; dec_cmd = 0; dec_rs1 = 0; dec_rs2 = 0;
      exe_cmd = 0; exe_rd = 0; exe_we = 0; mem_rd = 0; mem_we = 0;
      taken = 0; iack = 1; dreq = 0; dack = 0;
   endtask

   // one cycle: compare at negedge against model (and optional constant)
   task automatic step(input string tag, input bit use_k,
                       input logic [9:0] k);
      bit dm, rd, ld, im, kl, np, rr;
      logic [2:0] en;
      logic [9:0] exp, got;
      @(negedge clk);
      dm = dreq && !dack;
      rd = (exe_cmd == 2'd1 && taken) || exe_cmd == 2'd2;
      ld = exe_cmd == 2'd3 && exe_we && exe_rd != 0 &&
           (exe_rd == dec_rs1 || exe_rd == dec_rs2);
      im = !iack;
      en = 3'b111; kl = 0; np = 0; rr = 0;
      if (rst) begin
         en = 3'b000; kl = 1; np = 1;
         m_kills = 0; m_dwait = 0;
      end else if (m_dwait) begin
         if (!dack) en = 3'b000;
         else m_dwait = 0;
      end else if (m_kills > 0) begin
         kl = 1; np = 1;
         if (dm) en = 3'b000;
         else if (rd) begin rr = 1; m_kills = FC - 1; end
         else m_kills--;
      end else if (dm) begin
         en = 3'b000; m_dwait = 1;
      end else if (rd) begin
         rr = 1; kl = 1; np = 1; m_kills = FC - 1;
      end else if (ld) begin
         en = 3'b001; kl = 1;
      end else if (im) begin
         np = 1;
      end
      exp = rst ? ov(en, kl, np, rr, 2'b00, 2'b00)
                : ov(en, kl, np, rr, fsel(dec_rs1), fsel(dec_rs2));
      got = {if_enb, dec_enb, exe_enb, kill, nop, redir, fwa, fwb};
      chk(tag, {22'd0, got}, {22'd0, exp});
      if (use_k) chk({tag, "_k"}, {22'd0, got}, {22'd0, k});
      if (rst) begin
         m_stall = 0; m_flush = 0;
      end else begin
         if (!en[1]) m_stall++;
         if (rr) m_flush++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_perf(input string tag);
      chk({tag, "_stall"}, stall_cnt, PERF ? m_stall : 32'd0);
      chk({tag, "_flush"}, flush_cnt, PERF ? m_flush : 32'd0);
   endtask

   localparam logic [9:0] RUN_D = 10'b111_000_00_00;
   localparam logic [9:0] RST_D = 10'b000_110_00_00;

   initial begin
      n_vec = 0; n_err = 0;
      m_kills = 0; m_dwait = 0; m_stall = 0; m_flush = 0;
      idle();
      rst = 1;
      step("reset", 1, RST_D);
      rst = 0;
      step("idle", 1, RUN_D);
      chk_perf("perf_rst");

      exe_cmd = 3; exe_we = 1; exe_rd = 5; dec_rs2 = 5;
      step("ldu", 1, 10'b001_100_00_00);
      idle();
      step("ldu_after", 1, RUN_D);

      exe_cmd = 1; taken = 1;
      step("br_c0", 1, 10'b111_111_00_00);
      idle();
      step("br_c1", 1, 10'b111_110_00_00);
      step("br_c2", 1, RUN_D);

      exe_cmd = 1; taken = 0;
      step("br_nt", 1, RUN_D);

      exe_cmd = 2; exe_we = 1; exe_rd = 4; dec_rs1 = 4;
      step("jmp_fwd", 1, 10'b111_111_01_00);
      idle();
      step("jmp_c1", 1, 10'b111_110_00_00);
      step("jmp_c2", 1, RUN_D);

      exe_cmd = 1; taken = 1; dreq = 1;
      step("dm_br0", 1, 10'b000_000_00_00);
      step("dm_br1", 1, 10'b000_000_00_00);
      dack = 1;
      step("dm_br_ack", 1, RUN_D);
      dreq = 0; dack = 0;
      step("dm_br_redir", 1, 10'b111_111_00_00);
      idle();
      step("dm_br_kill", 1, 10'b111_110_00_00);

      dreq = 1;
      for (int i = 0; i < 4; i++) step("dmiss4", 1, 10'b000_000_00_00);
      dack = 1;
      step("dmiss_ack", 1, RUN_D);
      idle();

      dreq = 1;
      step("dm_rst0", 1, 10'b000_000_00_00);
      rst = 1;
      step("dm_rst1", 1, RST_D);
      idle();
      step("dm_rst2", 1, RUN_D);

      exe_cmd = 2;
      step("fl_rst0", 1, 10'b111_111_00_00);
      idle(); rst = 1;
      step("fl_rst1", 1, RST_D);
      rst = 0;
      step("fl_rst2", 1, RUN_D);

      exe_rd = 7; mem_rd = 7; exe_we = 1; mem_we = 1; dec_rs1 = 7;
      step("fwd_exe", 1, 10'b111_000_01_00);
      exe_we = 0;
      step("fwd_mem", 1, 10'b111_000_10_00);
      dec_rs1 = 0;
      step("fwd_r0", 1, RUN_D);
      exe_cmd = 3; exe_we = 1; dec_rs2 = 7; dec_rs1 = 3;
      step("fwd_ld", 1, 10'b001_100_00_10);
      idle();

      iack = 0;
      step("imiss0", 1, 10'b111_010_00_00);
      step("imiss1", 1, 10'b111_010_00_00);
      iack = 1;
      step("imiss_ack", 1, RUN_D);

      rst = 1;
      step("perf_rst", 1, RST_D);
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         exe_cmd = 2;
         step("perf_j", 1, 10'b111_111_00_00);
         idle();
         step("perf_k", 1, 10'b111_110_00_00);
      end
      dreq = 1;
      for (int i = 0; i < 5; i++) step("perf_dm", 0, '0);
      dack = 1;
      step("perf_ack", 1, RUN_D);
      idle();
      chk_perf("perf_plan");
      chk("perf_stall5", stall_cnt, PERF ? 32'd5 : 32'd0);
      chk("perf_flush3", flush_cnt, PERF ? 32'd3 : 32'd0);

      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 59) == 0);
         dec_cmd = 2'($urandom_range(0, 3));
         dec_rs1 = 5'($urandom_range(0, 3));
         dec_rs2 = 5'($urandom_range(0, 3));
         exe_cmd = 2'($urandom_range(0, 3));
         exe_rd  = 5'($urandom_range(0, 3));
         exe_we  = 1'($urandom_range(0, 1));
         mem_rd  = 5'($urandom_range(0, 3));
         mem_we  = 1'($urandom_range(0, 1));
         taken   = 1'($urandom_range(0, 1));
         iack    = ($urandom_range(0, 99) < 85);
         dreq    = ($urandom_range(0, 99) < 15);
         dack    = ($urandom_range(0, 99) < 40);
         step("rand", 0, '0);
         if (i % 500 == 499) chk_perf("perf_rand");
      end
      idle();
      step("final", 0, '0);
      chk_perf("perf_final");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
